// File: rtl/fwd_stall_unit.sv
// Forwarding and load-use stall unit: a shadow pipeline of in-flight writers drives EX bypass
// selects and an ID-stage load-use stall, with a stall counter and sticky hazard flag.
module fwd_stall_unit #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned FWD_DEPTH = 2,
  parameter int unsigned LOAD_LAT  = 1,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pipe_en,
  input  logic                       flush,
  input  logic                       id_valid,
  input  logic [NUM_SRC*ADDR_W-1:0]  id_src,
  input  logic [NUM_SRC-1:0]         id_src_used,
  input  logic [ADDR_W-1:0]          id_rd,
  input  logic                       id_reg_write,
  input  logic                       id_is_load,
  output logic                       stall,
  output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic                       hazard_err
);

  localparam int Depth   = int'(FWD_DEPTH);
  localparam int LoadLat = int'(LOAD_LAT);

  // Entry 0 is EX; entry s is s stages past EX.
  logic [FWD_DEPTH:0]             valid_q;
  logic [FWD_DEPTH:0]             rw_q;
  logic [FWD_DEPTH:0]             ld_q;
  logic [FWD_DEPTH:0][ADDR_W-1:0] rd_q;
  logic [NUM_SRC*ADDR_W-1:0]      src_q;
  logic [NUM_SRC-1:0]             used_q;
  logic [CNT_W-1:0]               cnt_q;
  logic                           err_q;

  logic                           issue;
  logic                           err_set;
  logic [NUM_SRC-1:0]             op_err;
  logic [NUM_SRC-1:0]             op_stall;

  // Bypass selects for the EX instruction; descending scan leaves the nearest writer in place.
  always_comb begin
    fwd_sel = '0;
    op_err  = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      for (int k = Depth; k >= 1; k--) begin
        if (valid_q[0] && used_q[i] && valid_q[k] && rw_q[k] && (rd_q[k] != '0) &&
            (rd_q[k] == src_q[i*ADDR_W +: ADDR_W])) begin
          if (!ld_q[k] || (k >= LoadLat + 1)) begin
            fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
            op_err[i]                 = 1'b0;
          end else begin
            fwd_sel[i*SEL_W +: SEL_W] = '0;
            op_err[i]                 = 1'b1;
          end
        end
      end
    end
    err_set = |op_err;
  end

  // Load-use check for the ID instruction against writers still short of their ready stage.
  always_comb begin
    op_stall = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      for (int j = Depth - 1; j >= 0; j--) begin
        if (valid_q[j] && rw_q[j] && (rd_q[j] != '0) &&
            (rd_q[j] == id_src[i*ADDR_W +: ADDR_W])) begin
          op_stall[i] = ld_q[j] && (j < LoadLat);
        end
      end
    end
    stall = id_valid && !flush && |(op_stall & id_src_used);
  end

  assign issue = id_valid && !stall && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      rw_q    <= '0;
      ld_q    <= '0;
      rd_q    <= '0;
      src_q   <= '0;
      used_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else if (pipe_en) begin
      valid_q <= {valid_q[FWD_DEPTH-1:0], issue};
      rw_q    <= {rw_q[FWD_DEPTH-1:0], issue & id_reg_write};
      ld_q    <= {ld_q[FWD_DEPTH-1:0], issue & id_is_load};
      rd_q    <= {rd_q[FWD_DEPTH-1:0], id_rd};
      src_q   <= id_src;
      used_q  <= issue ? id_src_used : '0;
      if (stall && !(&cnt_q)) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  assign stall_cnt  = cnt_q;
  assign hazard_err = err_q;

endmodule

// File: tb/tb_fwd_stall_unit.sv
// Directed bench: default instance (depth 2, load latency 1) and a depth 3 / latency 2 instance
// share stimulus; each phase checks one of them against hand-computed values.
module tb_fwd_stall_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_en;
  logic        flush;
  logic        id_valid;
  logic [9:0]  id_src;
  logic [1:0]  id_src_used;
  logic [4:0]  id_rd;
  logic        id_reg_write;
  logic        id_is_load;

  logic        stall_a, stall_b;
  logic [3:0]  sel_a, sel_b;
  logic [15:0] cnt_a, cnt_b;
  logic        err_a, err_b;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fwd_stall_unit u_def (
    .clk          (clk),
    .rst_n        (rst_n),
    .pipe_en      (pipe_en),
    .flush        (flush),
    .id_valid     (id_valid),
    .id_src       (id_src),
    .id_src_used  (id_src_used),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_is_load   (id_is_load),
    .stall        (stall_a),
    .fwd_sel      (sel_a),
    .stall_cnt    (cnt_a),
    .hazard_err   (err_a)
  );

  fwd_stall_unit #(
    .FWD_DEPTH (3),
    .LOAD_LAT  (2)
  ) u_d3 (
    .clk          (clk),
    .rst_n        (rst_n),
    .pipe_en      (pipe_en),
    .flush        (flush),
    .id_valid     (id_valid),
    .id_src       (id_src),
    .id_src_used  (id_src_used),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_is_load   (id_is_load),
    .stall        (stall_b),
    .fwd_sel      (sel_b),
    .stall_cnt    (cnt_b),
    .hazard_err   (err_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [1:0] used, input logic [4:0] rd, input logic rw,
                       input logic ld);
    id_valid     = v;
    id_src       = {s1, s0};
    id_src_used  = used;
    id_rd        = rd;
    id_reg_write = rw;
    id_is_load   = ld;
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    for (int c = 0; c < n; c++) step();
  endtask

  initial begin
    rst_n   = 1'b1;
    pipe_en = 1'b1;
    flush   = 1'b0;
    drive(1'b1, 5'($urandom), 5'($urandom), 2'b11, 5'($urandom), 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_stall", 32'(stall_a), 32'd0);
    check_eq("rst_sel", 32'(sel_a), 32'd0);
    check_eq("rst_cnt", 32'(cnt_a), 32'd0);
    check_eq("rst_err", 32'(err_a), 32'd0);
    step();
    step();
    check_eq("rst_hold_stall", 32'(stall_a), 32'd0);
    check_eq("rst_hold_sel", 32'(sel_a), 32'd0);
    rst_n = 1'b1;
    idle(1);

    // ALU producer forwarded from stage 1 then stage 2, never stalling
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0);
    check_eq("alu_stall0", 32'(stall_a), 32'd0);
    step();
    drive(1'b1, 5'd5, 5'd0, 2'b01, 5'd6, 1'b1, 1'b0);
    check_eq("alu_stall1", 32'(stall_a), 32'd0);
    step();
    check_eq("alu_sel_k1", 32'(sel_a), 32'h1);
    drive(1'b1, 5'd0, 5'd5, 2'b10, 5'd8, 1'b1, 1'b0);
    check_eq("alu_stall2", 32'(stall_a), 32'd0);
    step();
    check_eq("alu_sel_k2", 32'(sel_a), 32'h8);
    check_eq("alu_cnt", 32'(cnt_a), 32'd0);
    idle(3);

    // Load-use: one stall cycle, then forwarded from stage 2
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);
    step();
    drive(1'b1, 5'd7, 5'd0, 2'b01, 5'd10, 1'b1, 1'b0);
    check_eq("ld_stall_on", 32'(stall_a), 32'd1);
    step();
    check_eq("ld_stall_off", 32'(stall_a), 32'd0);
    check_eq("ld_cnt", 32'(cnt_a), 32'd1);
    check_eq("ld_bubble_sel", 32'(sel_a), 32'd0);
    step();
    check_eq("ld_sel_k2", 32'(sel_a), 32'h2);
    check_eq("ld_err", 32'(err_a), 32'd0);
    idle(3);

    // Nearest writer wins; unused operand ignored; r0 never forwarded
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd3, 5'd3, 2'b01, 5'd0, 1'b0, 1'b0);
    step();
    check_eq("nearest_unused", 32'(sel_a), 32'h1);
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd0, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
    step();
    check_eq("r0_no_fwd", 32'(sel_a), 32'd0);
    idle(3);

    // Freeze during a load-use stall
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd11, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd11, 5'd0, 2'b01, 5'd12, 1'b1, 1'b1);
    step();
    drive(1'b1, 5'd12, 5'd0, 2'b01, 5'd2, 1'b1, 1'b0);
    pipe_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq("frz_stall", 32'(stall_a), 32'd1);
      check_eq("frz_sel", 32'(sel_a), 32'h1);
      check_eq("frz_cnt", 32'(cnt_a), 32'd1);
    end
    pipe_en = 1'b1;
    step();
    check_eq("unfrz_cnt", 32'(cnt_a), 32'd2);
    check_eq("unfrz_stall", 32'(stall_a), 32'd0);
    idle(4);

    // Flush beats stall; the killed consumer would otherwise forward src1 from stage 2
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd14, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd13, 1'b1, 1'b1);
    step();
    flush = 1'b1;
    drive(1'b1, 5'd13, 5'd14, 2'b11, 5'd4, 1'b1, 1'b0);
    check_eq("flush_stall", 32'(stall_a), 32'd0);
    step();
    flush = 1'b0;
    check_eq("flush_bubble", 32'(sel_a), 32'd0);
    check_eq("flush_cnt", 32'(cnt_a), 32'd2);
    check_eq("flush_err", 32'(err_a), 32'd0);
    idle(4);

    // Reset in the middle of a stall drops it immediately
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd15, 1'b1, 1'b1);
    step();
    drive(1'b1, 5'd15, 5'd0, 2'b01, 5'd1, 1'b1, 1'b0);
    check_eq("mid_stall_on", 32'(stall_a), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_stall", 32'(stall_a), 32'd0);
    check_eq("mid_rst_cnt", 32'(cnt_a), 32'd0);
    check_eq("d3_rst_stall", 32'(stall_b), 32'd0);
    check_eq("d3_rst_cnt", 32'(cnt_b), 32'd0);
    check_eq("d3_rst_err", 32'(err_b), 32'd0);
    idle(1);
    rst_n = 1'b1;
    idle(1);

    // Depth 3 / latency 2: two stall cycles, forwarded from stage 3
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd20, 1'b1, 1'b1);
    step();
    drive(1'b1, 5'd20, 5'd0, 2'b01, 5'd21, 1'b1, 1'b0);
    check_eq("d3_stall_c0", 32'(stall_b), 32'd1);
    step();
    check_eq("d3_stall_c1", 32'(stall_b), 32'd1);
    check_eq("d3_cnt_c1", 32'(cnt_b), 32'd1);
    step();
    check_eq("d3_stall_c2", 32'(stall_b), 32'd0);
    check_eq("d3_cnt_c2", 32'(cnt_b), 32'd2);
    step();
    check_eq("d3_sel_k3", 32'(sel_b), 32'h3);
    check_eq("d3_cnt_end", 32'(cnt_b), 32'd2);
    idle(4);

    // Inject a load flag onto the stage-1 writer to force a not-ready match
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd9, 5'd0, 2'b01, 5'd22, 1'b1, 1'b0);
    step();
    check_eq("inj_pre_sel", 32'(sel_b), 32'h1);
    drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    force u_d3.ld_q = 4'b0010;
    #1;
    check_eq("inj_sel", 32'(sel_b), 32'd0);
    check_eq("inj_err_pre", 32'(err_b), 32'd0);
    step();
    release u_d3.ld_q;
    check_eq("inj_err_set", 32'(err_b), 32'd1);
    idle(4);
    check_eq("inj_err_sticky", 32'(err_b), 32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/fwd_stall_unit.md
# fwd_stall_unit

Parametrised forwarding and load-use stall unit for the pipelined MIPS core. It tracks in-flight destination registers through EX and the following FWD_DEPTH stages in an internal shadow pipeline. For the EX-stage instruction it drives per-source bypass selects. For the ID-stage instruction it raises a load-use stall and inserts a bubble. Its generalisations are N source operands, configurable forwarding depth and configurable load latency, plus a stall performance counter and a protocol-error flag.

## Interface
Parameters:
- ADDR_W, 5, register address width
- NUM_SRC, 2, source operands per instruction
- FWD_DEPTH, 2, number of post-EX stages that can forward (stage 1 = EX/MEM, 2 = MEM/WB, ...)
- LOAD_LAT, 1, load data first available at stage 1+LOAD_LAT; legal range 0..FWD_DEPTH-1
- CNT_W, 16, stall counter width
- SEL_W, $clog2(FWD_DEPTH+1), derived; not overridden

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock; asynchronous, active-low
- pipe_en  in  1  global pipeline advance; 0 freezes all state
- flush  in  1  kill the ID instruction (branch taken)
- id_valid  in  1  ID holds a valid instruction
- id_src  in  NUM_SRC*ADDR_W  ID source addresses, operand i at [i*ADDR_W +: ADDR_W]
- id_src_used  in  NUM_SRC  operand i actually read
- id_rd  in  ADDR_W  ID destination
- id_reg_write  in  1  ID writes id_rd
- id_is_load  in  1  ID is a load
- stall  out  1  hold PC/IF-ID, bubble into EX (combinational)
- fwd_sel  out  NUM_SRC*SEL_W  per-EX-operand select: 0 = register file, k = stage k
- stall_cnt  out  CNT_W  saturating count of stall cycles
- hazard_err  out  1  sticky: EX operand matched a not-yet-ready producer

## Operation
- Shadow pipeline: entries s = 0..FWD_DEPTH, fields {valid, rd, reg_write, is_load}. Entry 0 (EX) additionally holds src and src_used for every operand.
- Shift on a rising edge with pipe_en=1: entry s+1 <= entry s. Entry FWD_DEPTH is discarded. Entry 0 <= ID instruction if id_valid & !stall & !flush, otherwise a bubble (valid=0).
- Writer match at stage s for address a: valid & reg_write & rd!=0 & rd==a.
- Producer ready at stage k: !is_load | k >= 1+LOAD_LAT.
- fwd_sel operand i: taken from entry 0 src[i], only if src_used[i]. Nearest matching stage k in 1..FWD_DEPTH wins (lowest k). Result is k if that writer is ready, else 0 with hazard_err set. No match gives 0. Writers beyond FWD_DEPTH are assumed visible via register-file write-through.
- stall: asserted when id_valid & !flush and, for some used operand i, the nearest matching writer j in 0..FWD_DEPTH-1 has is_load=1 and j < LOAD_LAT. Non-load writers never stall.
- flush has priority over stall: stall=0 and a bubble is inserted.
- stall_cnt increments on an edge with pipe_en & stall and saturates at all-ones.
- hazard_err is set on an edge with pipe_en & error condition and is cleared only by reset.

## Timing
- Reset (async assert): all entries invalid, stall_cnt=0, hazard_err=0. Hence fwd_sel=0 and stall=0 from assertion until the first post-release instruction.
- fwd_sel depends only on registered state: valid from clock-to-q, no dependence on ID inputs.
- stall is combinational, same cycle as the ID inputs.
- ALU result forwarded with 0 stall cycles.
- Load-use distance 1 costs LOAD_LAT-0 stall cycles, i.e. max(0, LOAD_LAT - j) cycles for a producer at stage j.
- pipe_en=0: entries, counter and flag hold; outputs are stable. stall is still evaluated.
- Reset asserted mid-stall: stall drops immediately and in-flight entries are lost.

## Test plan
- Reset with id_valid=1 and random inputs -> stall=0, fwd_sel=0, stall_cnt=0, hazard_err=0.
- ALU rd=5, then consumer src0=5, then consumer src1=5 -> second instruction in EX shows fwd_sel[0]=1; third shows fwd_sel[1]=2; stall never asserted.
- Defaults: load rd=7, then consumer src0=7 -> stall=1 for exactly one cycle, stall_cnt=1; consumer in EX with fwd_sel[0]=2.
- Writers rd=3 at stages 1 and 2, consumer src0=3 -> fwd_sel[0]=1. Writer rd=0 with consumer src0=0 -> fwd_sel[0]=0. Unused matching operand -> 0.
- pipe_en=0 for 3 cycles during a load-use stall -> fwd_sel and stall_cnt frozen. flush=1 alongside stall -> stall=0 and a bubble enters EX.
- FWD_DEPTH=3, LOAD_LAT=2: load then consumer -> 2 stall cycles, fwd_sel=3, stall_cnt=2. Forced ready-violation via direct entry injection -> hazard_err=1 and sticky.
